// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit and the control FSM.
//   - FSM state codes and iteration count of the multiply/divide unit
//   - MemtoReg select codes that route HI/LO into the write-back selector
package mdu_pkg;

    localparam logic [1:0] MDU_IDLE = 2'd0;
    localparam logic [1:0] MDU_MULT = 2'd1;
    localparam logic [1:0] MDU_DIV  = 2'd2;

    localparam int MDU_ITER = 32;

    // Write-back selector codes used by mfhi / mflo
    localparam logic [3:0] MEMTOREG_HI = 4'b0101;
    localparam logic [3:0] MEMTOREG_LO = 4'b0100;

    typedef enum logic [1:0] {
        ST_IDLE = MDU_IDLE,
        ST_MULT = MDU_MULT,
        ST_DIV  = MDU_DIV
    } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: combinational magnitude extraction and sign correction for DIV.
// Ports:
//   num, den       : raw signed dividend / divisor (presented at acceptance)
//   num_mag,den_mag: their absolute values (most negative value maps to itself,
//                    which is the correct unsigned magnitude)
//   a_sign, b_sign : latched operand sign bits
//   quo_mag,rem_mag: unsigned quotient / remainder from the restoring divider
//   quo, rem       : signed results; quotient negative when signs differ,
//                    remainder takes the sign of the dividend
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
    input  logic             a_sign,
    input  logic             b_sign,
    input  logic [WIDTH-1:0] quo_mag,
    input  logic [WIDTH-1:0] rem_mag,
    output logic [WIDTH-1:0] num_mag,
    output logic [WIDTH-1:0] den_mag,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic neg);
        logic [WIDTH-1:0] one;
        one = {{(WIDTH-1){1'b0}}, 1'b1};
        if (neg) begin
            return ~v + one;
        end else begin
            return v;
        end
    endfunction

    // Magnitudes and sign-corrected results
    always_comb begin
        num_mag = cond_neg(num, num[WIDTH-1]);
        den_mag = cond_neg(den, den[WIDTH-1]);
        quo     = cond_neg(quo_mag, a_sign ^ b_sign);
        rem     = cond_neg(rem_mag, a_sign);
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle signed MULT (radix-2 Booth) / DIV (restoring)
// owning the HI and LO registers.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start_mult, start_div : one-cycle start pulses (MULT wins if both)
//   a, b                  : operands rs / rt, sampled on the accepting edge
//   hi, lo                : HI (product high / remainder), LO (product low / quotient)
//   busy                  : operation in progress
//   done                  : one-cycle pulse after HI/LO are written
//   div_zero              : last DIV had b == 0; cleared on next accepted start
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int         PW        = 2 * WIDTH + 1;
    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    mdu_state_e state_r, state_s;

    logic [WIDTH-1:0] a_r;
    logic             b_sign_r;
    logic [WIDTH-1:0] b_mag_r;
    logic [PW-1:0]    prod_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [5:0]       cnt_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;
    logic             done_r;
    logic             div_zero_r;

    logic             accept_s;
    logic             mult_fin_s;
    logic             div_fin_s;
    logic             dz_fin_s;
    logic             busy_s;

    logic [WIDTH:0]   booth_acc_s;
    logic [WIDTH:0]   booth_mcd_s;
    logic [WIDTH:0]   booth_sum_s;
    logic [PW-1:0]    prod_next_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quo_next_s;
    logic [WIDTH-1:0] num_mag_s;
    logic [WIDTH-1:0] den_mag_s;
    logic [WIDTH-1:0] quo_fix_s;
    logic [WIDTH-1:0] rem_fix_s;

    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .num     (a),
        .den     (b),
        .a_sign  (a_r[WIDTH-1]),
        .b_sign  (b_sign_r),
        .quo_mag (quo_next_s),
        .rem_mag (rem_next_s),
        .num_mag (num_mag_s),
        .den_mag (den_mag_s),
        .quo     (quo_fix_s),
        .rem     (rem_fix_s)
    );

    // Booth step: the add/sub is one bit wider than the accumulator so that
    // subtracting the most negative multiplicand cannot overflow before the shift.
    always_comb begin
        booth_acc_s = {prod_r[PW-1], prod_r[PW-1 -: WIDTH]};
        booth_mcd_s = {a_r[WIDTH-1], a_r};
        case (prod_r[1:0])
            2'b01:   booth_sum_s = booth_acc_s + booth_mcd_s;
            2'b10:   booth_sum_s = booth_acc_s - booth_mcd_s;
            default: booth_sum_s = booth_acc_s;
        endcase
        prod_next_s = {booth_sum_s, prod_r[WIDTH:1]};
    end

    // Restoring divide step on magnitudes; quo_r shifts the dividend out at
    // the top while quotient bits enter at the bottom.
    always_comb begin
        div_shift_s = {rem_r, quo_r[WIDTH-1]};
        if (div_shift_s >= {1'b0, b_mag_r}) begin
            rem_next_s = WIDTH'(div_shift_s - {1'b0, b_mag_r});
            quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s = div_shift_s[WIDTH-1:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state, acceptance and completion decode
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        mult_fin_s = 1'b0;
        div_fin_s  = 1'b0;
        dz_fin_s   = 1'b0;
        busy_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_mult) begin
                    state_s  = ST_MULT;
                    accept_s = 1'b1;
                    busy_s   = 1'b1;
                end else if (start_div) begin
                    state_s  = ST_DIV;
                    accept_s = 1'b1;
                    // divide by zero finishes next edge without ever being busy
                    busy_s   = (b != {WIDTH{1'b0}});
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_MULT: begin
                if (cnt_r == LAST_ITER) begin
                    state_s    = ST_IDLE;
                    mult_fin_s = 1'b1;
                end else begin
                    busy_s     = 1'b1;
                end
            end
            ST_DIV: begin
                if (b_mag_r == {WIDTH{1'b0}}) begin
                    state_s   = ST_IDLE;
                    dz_fin_s  = 1'b1;
                end else if (cnt_r == LAST_ITER) begin
                    state_s   = ST_IDLE;
                    div_fin_s = 1'b1;
                end else begin
                    busy_s    = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latches, iteration datapath, HI/LO and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r        <= {WIDTH{1'b0}};
            b_sign_r   <= 1'b0;
            b_mag_r    <= {WIDTH{1'b0}};
            prod_r     <= {PW{1'b0}};
            rem_r      <= {WIDTH{1'b0}};
            quo_r      <= {WIDTH{1'b0}};
            cnt_r      <= 6'd0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= mult_fin_s | div_fin_s | dz_fin_s;
            if (accept_s) begin
                a_r        <= a;
                b_sign_r   <= b[WIDTH-1];
                b_mag_r    <= den_mag_s;
                prod_r     <= {{WIDTH{1'b0}}, b, 1'b0};
                rem_r      <= {WIDTH{1'b0}};
                quo_r      <= num_mag_s;
                cnt_r      <= 6'd0;
                div_zero_r <= 1'b0;
            end else if (state_r == ST_MULT) begin
                prod_r <= prod_next_s;
                cnt_r  <= cnt_r + 6'd1;
                if (mult_fin_s) begin
                    hi_r <= prod_next_s[PW-1 -: WIDTH];
                    lo_r <= prod_next_s[WIDTH:1];
                end
            end else if (state_r == ST_DIV) begin
                if (dz_fin_s) begin
                    div_zero_r <= 1'b1;
                end else begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    cnt_r <= cnt_r + 6'd1;
                    if (div_fin_s) begin
                        hi_r <= rem_fix_s;
                        lo_r <= quo_fix_s;
                    end
                end
            end
        end
    end

    assign hi       = hi_r;
    assign lo       = lo_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed + randomized check of mult_div_unit against a
// plain-arithmetic reference model of HI/LO/div_zero and the completion timing.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;

    // reference state
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        m_dz = 1'b0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Signed MULT / DIV semantics straight from the arithmetic definition
    task automatic model_op(input bit is_mult, input logic [31:0] op_a, input logic [31:0] op_b);
        longint p;
        int     sa;
        int     sb;
        sa = op_a;
        sb = op_b;
        m_dz = 1'b0;
        if (is_mult) begin
            p    = longint'(sa) * longint'(sb);
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (op_b == 32'd0) begin
            m_dz = 1'b1;
        end else if (op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
            m_lo = 32'h8000_0000;
            m_hi = 32'd0;
        end else begin
            m_lo = sa / sb;
            m_hi = sa % sb;
        end
    endtask

    // Called at a negedge. Launches one op, checks busy, latency, stability
    // of HI/LO before completion, results, and returns in the done cycle.
    // intr > 0 pulses start_mult (to be ignored) at that cycle.
    task automatic run_op(input string tag, input bit is_mult,
                          input logic [31:0] op_a, input logic [31:0] op_b, input int intr);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          lat;
        int          exp_lat;
        bit          busy_ok;
        bit          stable_ok;
        old_hi    = m_hi;
        old_lo    = m_lo;
        exp_lat   = (!is_mult && op_b == 32'd0) ? 1 : 32;
        busy_ok   = 1'b1;
        stable_ok = 1'b1;
        lat       = -1;
        start_mult = is_mult;
        start_div  = !is_mult;
        a = op_a;
        b = op_b;
        @(negedge clk);
        start_mult = 1'b0;
        start_div  = 1'b0;
        a = $urandom;
        b = $urandom;
        check_eq({tag, ".done_e0"}, {63'd0, done}, 64'd0);
        check_eq({tag, ".dz_clr"}, {63'd0, div_zero}, 64'd0);
        model_op(is_mult, op_a, op_b);
        for (int k = 1; k <= 40; k++) begin
            if (busy !== (exp_lat != 1)) busy_ok = 1'b0;
            if (hi !== old_hi || lo !== old_lo) stable_ok = 1'b0;
            start_mult = (k == intr);
            @(negedge clk);
            start_mult = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        check_eq({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, ".busy_run"}, {63'd0, busy_ok}, 64'd1);
        check_eq({tag, ".hold"}, {63'd0, stable_ok}, 64'd1);
        check_eq({tag, ".busy_done"}, {63'd0, busy}, 64'd0);
        check_eq({tag, ".hilo"}, {hi, lo}, {m_hi, m_lo});
        check_eq({tag, ".div_zero"}, {63'd0, div_zero}, {63'd0, m_dz});
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit          quiet;
        reset = 1'b1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a = 32'd0;
        b = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst.hilo", {hi, lo}, 64'd0);
        check_eq("rst.busy", {63'd0, busy}, 64'd0);
        check_eq("rst.done", {63'd0, done}, 64'd0);
        check_eq("rst.dz", {63'd0, div_zero}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("t1_mult", 1'b1, 32'd7, 32'hFFFF_FFFD, 0);
        check_eq("t1_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        // back-to-back: launched during the done cycle
        run_op("t2_mult", 1'b1, 32'h8000_0000, 32'h8000_0000, 0);
        check_eq("t2_const", {hi, lo}, 64'h4000_0000_0000_0000);
        run_op("t3_div", 1'b0, 32'hFFFF_FFF9, 32'd2, 0);
        check_eq("t3_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("t4_pre", 1'b1, 32'd102, 32'h2AAA_AAAB, 0);
        check_eq("t4_pre_const", {hi, lo}, 64'h0000_0011_0000_0022);
        run_op("t4_dz", 1'b0, 32'd5, 32'd0, 0);
        check_eq("t4_dz_const", {hi, lo, 31'd0, div_zero}, {64'h0000_0011_0000_0022, 32'd1});
        run_op("t5_wrap", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check_eq("t5_const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op("t5_intr", 1'b0, 32'd1000, 32'hFFFF_FFF3, 10);

        // t6: reset at iteration 10 of a MULT
        start_mult = 1'b1;
        a = 32'd123;
        b = 32'd456;
        @(negedge clk);
        start_mult = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        m_dz = 1'b0;
        check_eq("t6.busy", {63'd0, busy}, 64'd0);
        check_eq("t6.hilo", {hi, lo}, 64'd0);
        check_eq("t6.done", {63'd0, done}, 64'd0);
        quiet = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check_eq("t6.quiet", {63'd0, quiet}, 64'd1);
        run_op("t6_fresh", 1'b1, 32'hFFFF_0001, 32'd77, 0);

        // randomized mix, including zero divisors and extreme operands
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       ra = 32'h8000_0000;
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), ra, rb,
                   int'($urandom_range(0, 3)) == 0 ? int'($urandom_range(1, 30)) : 0);
        end

        @(negedge clk);
        check_eq("final.done_drop", {63'd0, done}, 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Multi-cycle signed multiply/divide unit that owns the HI and LO registers of the processor.
- Its `hi`/`lo` outputs feed the HI and LO inputs of the MemtoReg write-back selector, which `mfhi`/`mflo` use.
- The control FSM starts an operation with a one-cycle pulse, then waits on `busy`/`done` before issuing a dependent `mfhi`/`mflo`.

## Interface

Parameters:
- `WIDTH`, default 32: operand and HI/LO width.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on its rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `start_mult`: input, 1 bit. One-cycle pulse that requests a signed MULT of `a*b`.
- `start_div`: input, 1 bit. One-cycle pulse that requests a signed DIV of `a/b`.
- `a`: input, WIDTH bits. Operand rs. Sampled only on the accepting edge.
- `b`: input, WIDTH bits. Operand rt. Sampled only on the accepting edge.
- `hi`: output, WIDTH bits. HI register: product upper half, or remainder.
- `lo`: output, WIDTH bits. LO register: product lower half, or quotient.
- `busy`: output, 1 bit. High while an operation is in progress.
- `done`: output, 1 bit. One-cycle pulse in the cycle after HI/LO are written.
- `div_zero`: output, 1 bit. Set when a DIV completes with `b==0`; cleared by the next accepted start or by reset.

## Operation

States: IDLE, MULT, DIV. A 6-bit iteration counter `cnt` tracks progress.

Reset values:
- state IDLE
- `hi = lo = 0`
- `busy = done = div_zero = 0`
- `cnt = 0`

Accepting a start:
- A start is accepted only in IDLE.
- Starts while `busy` are ignored; there is no queue.
- If `start_mult` and `start_div` are both high, MULT wins.
- On acceptance, `a` and `b` are latched into internal operand registers and `div_zero` is cleared.

MULT (radix-2 Booth):
- Uses a 2*WIDTH+1-bit product/multiplier register plus an arithmetic right shift.
- Runs for exactly WIDTH iteration cycles.
- On the final iteration edge, `{hi, lo}` is loaded with the full signed 64-bit product.

DIV (restoring):
- Operates on operand magnitudes, WIDTH iterations.
- On the final edge, sign correction is applied:
  - quotient is negated if `a[31]^b[31]`;
  - remainder takes the sign of `a`.
- Results: `lo` = quotient, `hi` = remainder.
- `0x80000000 / 0xFFFFFFFF` wraps: `lo = 0x80000000`, `hi = 0`.

DIV with `b == 0`:
- No iterations are run.
- On the edge after acceptance: `div_zero = 1`, `done = 1`, state returns to IDLE.
- `hi` and `lo` are unchanged.

Result visibility:
- `hi`/`lo` change only at operation completion or reset.
- Intermediate values are never visible on the outputs.

Reset during an operation:
- State is aborted to IDLE.
- `hi`/`lo` are cleared.
- No `done` pulse is produced.

## Timing

- Call the accepting edge E0.
- `busy` goes high after E0 and stays high through the edge that writes HI/LO.
- MULT and non-zero DIV:
  - iterations occur on E1..E32;
  - `hi`/`lo` update at E32;
  - `done = 1` and `busy = 0` during the cycle after E32;
  - `done` drops at E33.
- DIV by zero: `done` and `div_zero` are high in the cycle after E1, and `busy` is never asserted.
- Back-to-back: a start presented during the `done` cycle is accepted, since state is already IDLE. This gives a 33-cycle throughput.
- `done` is never high for two consecutive cycles.

## Structure

- Shared package `mdu_pkg` holds:
  - state localparams `MDU_IDLE = 2'd0`, `MDU_MULT = 2'd1`, `MDU_DIV = 2'd2`;
  - `MDU_ITER = 32`.
- The same package exports the MemtoReg select codes for HI (`4'b0101`) and LO (`4'b0100`), so the control FSM and this unit share one definition.
- One sub-module is natural: `mdu_sign_fix`, a combinational block for magnitude extraction and final sign correction in DIV.
- The Booth datapath stays inline in `mult_div_unit`.

## Test plan

1. MULT with `a = 7`, `b = 0xFFFFFFFD` (-3):
   - `done` appears 32 cycles after E0;
   - `hi = 0xFFFFFFFF`, `lo = 0xFFFFFFEB`.
2. MULT with `a = b = 0x80000000`: `hi = 0x40000000`, `lo = 0x00000000`.
3. DIV with `a = 0xFFFFFFF9` (-7), `b = 2`: `lo = 0xFFFFFFFD` (-3), `hi = 0xFFFFFFFF` (-1).
4. DIV by zero:
   - preload `hi = 0x11`, `lo = 0x22` via a prior MULT;
   - DIV with `a = 5`, `b = 0`;
   - expect `done` and `div_zero` one cycle after E0, `hi`/`lo` unchanged, `busy` never high.
5. DIV `0x80000000 / 0xFFFFFFFF`:
   - expect `lo = 0x80000000`, `hi = 0`;
   - in a separate run, assert `start_mult` at cycle 10 of a DIV; it must be ignored and the DIV result unaffected.
6. Reset at iteration 10 of a MULT:
   - next cycle `busy = 0`, `hi = lo = 0`, no `done`;
   - a fresh MULT started afterwards completes normally in 32 cycles.
